// File: rtl/feedback_pkg.sv
// Shared helpers for the multi-channel leaky-integrator feedback loop.
// Width narrowing is done on a 64-bit signed carrier so one function serves every width.
package feedback_pkg;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Keep the low w bits and re-extend their sign bit.
  function automatic logic signed [63:0] wrap_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/feedback_fit.sv
// Signed IN_W -> OUT_W narrowing: clamps when FEEDBACK_SAT_EN is defined, otherwise wraps.
// Purely combinational, no handshake.
module feedback_fit
  import feedback_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [63:0] wide;
  logic signed [63:0] fitted;
  logic               unused_hi;

  always_comb begin
    wide = {{(64 - IN_W){din[IN_W-1]}}, din};
`ifdef FEEDBACK_SAT_EN
    fitted = sat_signed(wide, OUT_W);
`else
    fitted = wrap_signed(wide, OUT_W);
`endif
  end

  assign dout      = fitted[OUT_W-1:0];
  assign unused_hi = ^fitted[63:OUT_W];

endmodule

// File: rtl/feedback_loop_mc.sv
// Time-multiplexed leaky integrator y = x + y - (y >>> SHIFT); 1-cycle latency, in_ready = !out_valid || out_ready.
// Overflow mode selected by FEEDBACK_SAT_EN (saturate) or its absence (wrap).
module feedback_loop_mc
  import feedback_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int CHANNELS = 4,
  parameter int SHIFT    = 3,
  localparam int CH_W    = ch_w(CHANNELS)
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_chan,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     chan_err
);

  logic signed [ACC_W-1:0]  acc [CHANNELS];
  logic signed [ACC_W-1:0]  cur;
  logic signed [ACC_W-1:0]  leak;
  logic signed [ACC_W+1:0]  cur_x;
  logic signed [ACC_W+1:0]  din_x;
  logic signed [ACC_W+1:0]  leak_x;
  logic signed [ACC_W+1:0]  nxt;
  logic signed [ACC_W-1:0]  acc_fit;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [DATA_W-1:0] data_fit;
  logic                     accept;
  logic                     chan_ok;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign chan_ok  = (32'(in_chan) < CHANNELS);

  // A simultaneous clear makes the accepted sample start from an empty accumulator.
  assign cur    = (clear || !chan_ok) ? '0 : acc[in_chan];
  assign leak   = cur >>> SHIFT;
  assign cur_x  = {{2{cur[ACC_W-1]}}, cur};
  assign din_x  = {{(ACC_W + 2 - DATA_W){in_data[DATA_W-1]}}, in_data};
  assign leak_x = {{2{leak[ACC_W-1]}}, leak};
  assign nxt    = cur_x + din_x - leak_x;

  feedback_fit #(.IN_W(ACC_W + 2), .OUT_W(ACC_W)) u_fit_acc (
    .din  (nxt),
    .dout (acc_fit)
  );

  assign scaled = acc_fit >>> SHIFT;

  feedback_fit #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_fit_data (
    .din  (scaled),
    .dout (data_fit)
  );

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      chan_err  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clear) begin
        for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      end
      if (accept) begin
        if (chan_ok) begin
          acc[in_chan] <= acc_fit;
          out_data     <= data_fit;
          out_chan     <= in_chan;
          out_valid    <= 1'b1;
        end else begin
          chan_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_feedback_loop_mc.sv
// Randomized and directed bench: instance a (defaults) and instance b (ACC_W=10, 3 channels).
module tb_feedback_loop_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst, a_valid, a_ready, a_clear, a_ovld, a_ordy, a_err;
  logic signed [7:0] a_data, a_odat;
  logic [1:0]        a_chan, a_ochan;
  logic              b_rst, b_valid, b_ready, b_clear, b_ovld, b_ordy, b_err;
  logic signed [7:0] b_data, b_odat;
  logic [1:0]        b_chan, b_ochan;

  feedback_loop_mc dut_a (
    .system1000(clk), .system1000_rst(a_rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_chan(a_chan), .clear(a_clear), .out_valid(a_ovld),
    .out_ready(a_ordy), .out_data(a_odat), .out_chan(a_ochan), .chan_err(a_err));

  feedback_loop_mc #(.ACC_W(10), .CHANNELS(3)) dut_b (
    .system1000(clk), .system1000_rst(b_rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_chan(b_chan), .clear(b_clear), .out_valid(b_ovld),
    .out_ready(b_ordy), .out_data(b_odat), .out_chan(b_ochan), .chan_err(b_err));

  int n_checks = 0;
  int n_errors = 0;

  // reference state, index 0 = dut_a, 1 = dut_b
  int m_acc [2][4];
  int m_ov  [2];
  int m_od  [2];
  int m_oc  [2];
  int m_err [2];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int s);
    int p = 1 << s;
    int q = a / p;
    if (a < 0 && q * p != a) q = q - 1;
    return q;
  endfunction

  function automatic int fit(input int v, input int w);
    int half = 1 << (w - 1);
`ifdef FEEDBACK_SAT_EN
    if (v > half - 1) return half - 1;
    if (v < -half) return -half;
    return v;
`else
    int m = 1 << w;
    int r = v % m;
    if (r < 0) r = r + m;
    if (r >= half) r = r - m;
    return r;
`endif
  endfunction

  task automatic mdl_reset(input int id);
    for (int i = 0; i < 4; i++) m_acc[id][i] = 0;
    m_ov[id] = 0; m_od[id] = 0; m_oc[id] = 0; m_err[id] = 0;
  endtask

  task automatic mdl(input int id, input logic v, input int ch, input int d, input logic clr, input logic ordy);
    int  nch  = (id == 0) ? 4 : 3;
    int  accw = (id == 0) ? 16 : 10;
    int  a;
    bit  take = v && (m_ov[id] == 0 || ordy);
    if (m_ov[id] != 0 && ordy) m_ov[id] = 0;
    if (clr) for (int i = 0; i < 4; i++) m_acc[id][i] = 0;
    if (take) begin
      if (ch < nch) begin
        a = fit(m_acc[id][ch] + d - floor_div(m_acc[id][ch], 3), accw);
        m_acc[id][ch] = a;
        m_od[id] = fit(floor_div(a, 3), 8);
        m_oc[id] = ch;
        m_ov[id] = 1;
      end else begin
        m_err[id] = 1;
      end
    end
  endtask

  task automatic check_outs(input int id);
    if (id == 0) begin
      check("a_out_valid", a_ovld, m_ov[0]);
      check("a_out_data", a_odat, m_od[0]);
      check("a_out_chan", a_ochan, m_oc[0]);
      check("a_chan_err", a_err, m_err[0]);
    end else begin
      check("b_out_valid", b_ovld, m_ov[1]);
      check("b_out_data", b_odat, m_od[1]);
      check("b_out_chan", b_ochan, m_oc[1]);
      check("b_chan_err", b_err, m_err[1]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input int id, input logic v, input int ch, input int d, input logic clr, input logic ordy);
    logic [1:0]        c2 = ch[1:0];
    logic signed [7:0] d8 = d[7:0];
    if (id == 0) begin
      a_valid = v; a_chan = c2; a_data = d8; a_clear = clr; a_ordy = ordy;
    end else begin
      b_valid = v; b_chan = c2; b_data = d8; b_clear = clr; b_ordy = ordy;
    end
    #1;
    check(id == 0 ? "a_in_ready" : "b_in_ready", id == 0 ? a_ready : b_ready,
          (m_ov[id] == 0 || ordy) ? 1 : 0);
    mdl(id, v, ch, d, clr, ordy);
    @(negedge clk);
    check_outs(id);
  endtask

  task automatic pulse_reset(input int id);
    if (id == 0) a_rst = 1'b1; else b_rst = 1'b1;
    @(negedge clk);
    if (id == 0) a_rst = 1'b0; else b_rst = 1'b0;
    mdl_reset(id);
    check_outs(id);
  endtask

  initial begin
    logic signed [7:0] held;
    int step_exp [4];
    bit seen_neg;
    step_exp[0] = 1; step_exp[1] = 1; step_exp[2] = 2; step_exp[3] = 3;
    {a_valid, a_clear, a_ordy, a_chan, a_data} = '0;
    {b_valid, b_clear, b_ordy, b_chan, b_data} = '0;
    a_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    mdl_reset(0); mdl_reset(1);
    check_outs(0); check_outs(1);

    // step response on ch0
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8, 0, 1);
      check("step_seq", a_odat, step_exp[i]);
    end
    for (int i = 0; i < 80; i++) step(0, 1, 0, 8, 0, 1);
    check("step_final", a_odat, 8);

    // channel isolation
    pulse_reset(0);
    for (int i = 0; i < 20; i++) step(0, 1, 1 + (i % 2), (i % 2) ? -100 : 100, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    check("iso_ch0", a_odat, 0);
    step(0, 1, 3, 0, 0, 1);
    check("iso_ch3", a_odat, 0);

    // backpressure
    step(0, 1, 1, 50, 0, 1);
    held = a_odat;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2, 77, 0, 0);
      check("bp_hold", a_odat, held);
      check("bp_ready", a_ready, 0);
    end
    step(0, 1, 2, 77, 0, 1);
    check("bp_release_chan", a_ochan, 2);

    // clear with a simultaneous accept
    for (int i = 0; i < 10; i++) step(0, 1, i % 2, 40, 0, 1);
    step(0, 1, 0, -5, 1, 1);
    check("clear_accept", a_odat, -1);
    step(0, 1, 1, 0, 0, 1);
    check("clear_ch1", a_odat, 0);

    // randomized traffic on dut_a
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255) - 128,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);

    // overflow on the 10-bit accumulator
    seen_neg = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 127, 0, 1);
      if (b_odat < 0) seen_neg = 1;
    end
`ifdef FEEDBACK_SAT_EN
    check("ovf_sat", b_odat, 63);
`else
    check("ovf_wrap_neg", seen_neg, 1);
`endif

    // bad channel, then mid-stream reset
    step(1, 1, 1, 20, 0, 0);
    step(1, 1, 3, 55, 0, 1);
    step(1, 1, 3, 55, 0, 1);
    check("bad_err", b_err, 1);
    check("bad_noout", b_ovld, 0);
    step(1, 1, 1, 30, 0, 0);
    pulse_reset(1);
    step(1, 1, 0, 16, 0, 1);
    check("post_rst_ch0", b_odat, 2);

    // randomized traffic on dut_b including bad channels
    for (int i = 0; i < 300; i++)
      step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 255) - 128,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
